// File: rtl/mem_port_arb_pkg.sv
// Shared encodings for the port-B arbiter: enable/width codes, FSM states, master ids
// and the access-legality check.
package mem_port_arb_pkg;

    localparam logic MM_ENB_R = 1'b0;
    localparam logic MM_ENB_W = 1'b1;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef enum logic [1:0] {
        MW_Byte = 2'd0,
        MW_Half = 2'd1,
        MW_Word = 2'd2
    } mem_width_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
    } acc_t;

    function automatic logic acc_err(input logic [1:0] size, input logic [31:0] addr,
                                     input logic [31:0] limit);
        return (addr >= limit) ||
               (size == MW_Word && addr[1:0] != 2'b00) ||
               (size == MW_Half && addr[0]);
    endfunction

endpackage

// File: rtl/mem_port_arb_if.sv
// Requester handshakes plus memory port B, bundled; slave = arbiter view, master = environment view.
interface mem_port_arb_if #(parameter int DW = 32);
    logic          m0_req;
    logic [31:0]   m0_addr;
    logic          m0_ack;
    logic          m0_err;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [1:0]    m1_size;
    logic [31:0]   m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_ack;
    logic          m1_err;
    logic [DW-1:0] m1_rdata;

    logic          mem_enwr;
    logic [1:0]    mem_size;
    logic [31:0]   mem_abus;
    logic [DW-1:0] mem_dbusw;
    logic [DW-1:0] mem_dbusr;

    modport slave (
        input  m0_req, m0_addr,
        output m0_ack, m0_err, m0_rdata,
        input  m1_req, m1_we, m1_size, m1_addr, m1_wdata,
        output m1_ack, m1_err, m1_rdata,
        output mem_enwr, mem_size, mem_abus, mem_dbusw,
        input  mem_dbusr
    );

    modport master (
        output m0_req, m0_addr,
        input  m0_ack, m0_err, m0_rdata,
        output m1_req, m1_we, m1_size, m1_addr, m1_wdata,
        input  m1_ack, m1_err, m1_rdata,
        input  mem_enwr, mem_size, mem_abus, mem_dbusw,
        output mem_dbusr
    );
endinterface

// File: rtl/mem_port_arb_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the one not granted last.
module rr_arb2
    import mem_port_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);
    always_comb begin
        gnt[0] = req[0] & (~req[1] | (last == M1));
        gnt[1] = req[1] & (~req[0] | (last == M0));
    end
endmodule

// File: rtl/mem_port_arb.sv
// Shares memory port B between instruction fetch (M0) and the LSU (M1):
// IDLE -> ISSUE -> RESP with all outputs registered; illegal accesses skip ISSUE.
module mem_port_arb
    import mem_port_arb_pkg::*;
#(
    parameter int MEM_BYTES = 4096,
    parameter int DW        = 32
) (
    input  logic           clk,
    input  logic           rst,
    mem_port_arb_if.slave  bus,
    output logic           busy
);
    state_e     state;
    logic       last_gnt;
    logic       cur;
    logic [1:0] gnt;
    logic       win;
    logic       bad;
    acc_t       acc;

    rr_arb2 u_arb (
        .req  ({bus.m1_req, bus.m0_req}),
        .last (last_gnt),
        .gnt  (gnt)
    );

    // M0 is always presented as a word read so one check covers both masters.
    always_comb begin
        win = gnt[1] ? M1 : M0;
        if (gnt[1]) begin
            acc.we   = bus.m1_we;
            acc.size = bus.m1_size;
            acc.addr = bus.m1_addr;
        end else begin
            acc.we   = 1'b0;
            acc.size = MW_Word;
            acc.addr = bus.m0_addr;
        end
        bad = acc_err(acc.size, acc.addr, 32'(MEM_BYTES));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            last_gnt      <= M1;
            cur           <= M0;
            bus.mem_enwr  <= MM_ENB_R;
            bus.mem_size  <= MW_Word;
            bus.mem_abus  <= 32'd0;
            bus.mem_dbusw <= {DW{1'b0}};
            bus.m0_ack    <= 1'b0;
            bus.m0_err    <= 1'b0;
            bus.m0_rdata  <= {DW{1'b0}};
            bus.m1_ack    <= 1'b0;
            bus.m1_err    <= 1'b0;
            bus.m1_rdata  <= {DW{1'b0}};
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|gnt) begin
                        last_gnt <= win;
                        cur      <= win;
                        busy     <= 1'b1;
                        if (bad) begin
                            // Rejected: answer directly, port B stays in read mode.
                            state <= ST_RESP;
                            if (win == M0) begin
                                bus.m0_ack   <= 1'b1;
                                bus.m0_err   <= 1'b1;
                                bus.m0_rdata <= {DW{1'b0}};
                            end else begin
                                bus.m1_ack   <= 1'b1;
                                bus.m1_err   <= 1'b1;
                                bus.m1_rdata <= {DW{1'b0}};
                            end
                        end else begin
                            state         <= ST_ISSUE;
                            bus.mem_enwr  <= acc.we ? MM_ENB_W : MM_ENB_R;
                            bus.mem_size  <= acc.size;
                            bus.mem_abus  <= acc.addr;
                            bus.mem_dbusw <= (win == M1) ? bus.m1_wdata : {DW{1'b0}};
                        end
                    end
                end
                ST_ISSUE: begin
                    state        <= ST_RESP;
                    bus.mem_enwr <= MM_ENB_R;
                    if (cur == M0) begin
                        bus.m0_ack   <= 1'b1;
                        bus.m0_err   <= 1'b0;
                        bus.m0_rdata <= bus.mem_dbusr;
                    end else begin
                        bus.m1_ack   <= 1'b1;
                        bus.m1_err   <= 1'b0;
                        bus.m1_rdata <= (bus.mem_enwr == MM_ENB_W) ? {DW{1'b0}} : bus.mem_dbusr;
                    end
                end
                ST_RESP: begin
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    bus.m0_ack <= 1'b0;
                    bus.m0_err <= 1'b0;
                    bus.m1_ack <= 1'b0;
                    bus.m1_err <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: byte-array memory on port B, byte-array reference model,
// directed scenarios followed by randomized single and contended accesses.
module tb_mem_port_arb;
    import mem_port_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;

    mem_port_arb_if #(.DW(32)) bus ();

    mem_port_arb #(.MEM_BYTES(4096), .DW(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // Port-B memory (port A is a plain word-write path used for preload)
    logic [7:0]  mem [0:4095];
    logic        pa_we = 1'b0;
    logic [11:0] pa_addr = 12'd0;
    logic [31:0] pa_data = 32'd0;
    logic [11:0] ra;
    int          wr_cnt = 0;

    always @(posedge clk) begin
        if (pa_we)
            for (int i = 0; i < 4; i++) mem[pa_addr + 12'(i)] <= pa_data[8*i +: 8];
        if (bus.mem_enwr == MM_ENB_W) begin
            for (int i = 0; i < (1 << bus.mem_size); i++)
                mem[12'(bus.mem_abus + 32'(i))] <= bus.mem_dbusw[8*i +: 8];
            wr_cnt <= wr_cnt + 1;
        end
    end

    always_comb begin
        ra = bus.mem_abus[11:0];
        case (bus.mem_size)
            MW_Byte: bus.mem_dbusr = {24'd0, mem[ra]};
            MW_Half: bus.mem_dbusr = {16'd0, mem[ra + 12'd1], mem[ra]};
            default: bus.mem_dbusr = {mem[ra + 12'd3], mem[ra + 12'd2], mem[ra + 12'd1], mem[ra]};
        endcase
    end

    // Reference model
    logic [7:0]  ref_mem [0:4095];
    logic        exp_last;
    int          n_chk = 0;
    int          n_pass = 0;
    localparam int IMG_N = 12;
    logic [31:0] img [0:IMG_N-1];

    function automatic logic [31:0] ref_rd(input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < (1 << sz); i++)
            v = v | (32'(ref_mem[(a + 32'(i)) % 4096]) << (8 * i));
        return v;
    endfunction

    function automatic void ref_wr(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        for (int i = 0; i < (1 << sz); i++)
            ref_mem[(a + 32'(i)) % 4096] = d[8*i +: 8];
    endfunction

    function automatic logic ref_err(input logic [31:0] a, input logic [1:0] sz);
        return (a >= 32'd4096) || ((a % (32'd1 << sz)) != 32'd0);
    endfunction

    function automatic logic [31:0] pick_addr();
        if ($urandom_range(0, 7) == 0) return 32'hFF8 + $urandom_range(0, 15);
        return 32'h900 + $urandom_range(0, 63);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One access from either or both masters; predictions follow the arbitration rules.
    task automatic pair(input bit r0, input logic [31:0] a0, input bit r1, input logic we,
                        input logic [1:0] sz, input logic [31:0] a1, input logic [31:0] wd,
                        output logic [31:0] rd0, output logic [31:0] rd1);
        logic e0, e1, w1;
        logic [31:0] x0, x1;
        int l0, l1, cyc;
        bit d0, d1;
        e0 = ref_err(a0, MW_Word);
        e1 = ref_err(a1, sz);
        w1 = r1 && (!r0 || exp_last == M0);
        l0 = e0 ? 1 : 2;
        l1 = e1 ? 1 : 2;
        x0 = 32'd0;
        x1 = 32'd0;
        if (w1) begin
            if (!e1) begin
                x1 = we ? 32'd0 : ref_rd(a1, sz);
                if (we) ref_wr(a1, sz, wd);
            end
            if (r0) begin
                l0 += l1 + 1;
                if (!e0) x0 = ref_rd(a0, MW_Word);
            end
            exp_last = r0 ? M0 : M1;
        end else begin
            if (!e0) x0 = ref_rd(a0, MW_Word);
            if (r1) begin
                l1 += l0 + 1;
                if (!e1) begin
                    x1 = we ? 32'd0 : ref_rd(a1, sz);
                    if (we) ref_wr(a1, sz, wd);
                end
            end
            exp_last = r1 ? M1 : M0;
        end
        if (!r0) l0 = -1;
        if (!r1) l1 = -1;
        rd0 = 32'd0;
        rd1 = 32'd0;
        bus.m0_req = r0;  bus.m0_addr = a0;
        bus.m1_req = r1;  bus.m1_we = we;  bus.m1_size = sz;  bus.m1_addr = a1;  bus.m1_wdata = wd;
        d0 = !r0;
        d1 = !r1;
        cyc = 0;
        while (!(d0 && d1) && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.m0_ack || bus.m1_ack) chk("ack_overlap", 32'(bus.m0_ack & bus.m1_ack), 32'd0);
            if (bus.m0_ack) begin
                chk("m0_latency", cyc, l0);
                chk("m0_err", 32'(bus.m0_err), 32'(e0));
                if (!e0) chk("m0_rdata", bus.m0_rdata, x0);
                rd0 = bus.m0_rdata;
                bus.m0_req = 1'b0;
                d0 = 1'b1;
            end
            if (bus.m1_ack) begin
                chk("m1_latency", cyc, l1);
                chk("m1_err", 32'(bus.m1_err), 32'(e1));
                if (!e1) chk("m1_rdata", bus.m1_rdata, x1);
                rd1 = bus.m1_rdata;
                bus.m1_req = 1'b0;
                d1 = 1'b1;
            end
        end
        chk("acks_received", {30'd0, d0, d1}, 32'd3);
        @(posedge clk); #1;
        chk("idle_after", {30'd0, busy, bus.m0_ack | bus.m1_ack}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd0, rd1, a;
        int n, cyc, k, wc, sel;
        logic exp_first;
        bit done;

        bus.m0_req = 1'b0;  bus.m0_addr = 32'd0;
        bus.m1_req = 1'b0;  bus.m1_we = 1'b0;  bus.m1_size = MW_Word;
        bus.m1_addr = 32'd0;  bus.m1_wdata = 32'd0;
        exp_last = M1;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'd0;
        for (int i = 0; i < IMG_N; i++) begin
            img[i] = (i == 0) ? 32'h00000013 : (i == IMG_N - 1) ? 32'h0000FFFF : {$urandom} | 32'h10000;
            ref_wr(32'h800 + 32'(4 * i), MW_Word, img[i]);
        end

        // Preload through port A while the arbiter is held in reset.
        @(posedge clk); #1;
        for (int i = 0; i < 1024 + IMG_N; i++) begin
            pa_we = 1'b1;
            pa_addr = (i < 1024) ? 12'(4 * i) : 12'(32'h800 + 32'(4 * (i - 1024)));
            pa_data = (i < 1024) ? 32'd0 : img[i - 1024];
            @(posedge clk); #1;
        end
        pa_we = 1'b0;

        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_enwr", 32'(bus.mem_enwr), 32'(MM_ENB_R));
        chk("rst_size", 32'(bus.mem_size), 32'(MW_Word));
        chk("rst_abus", bus.mem_abus, 32'd0);
        chk("rst_dbusw", bus.mem_dbusw, 32'd0);
        chk("rst_acks", {30'd0, bus.m0_ack, bus.m1_ack}, 32'd0);
        chk("rst_errs", {30'd0, bus.m0_err, bus.m1_err}, 32'd0);
        chk("rst_m0_rdata", bus.m0_rdata, 32'd0);
        chk("rst_m1_rdata", bus.m1_rdata, 32'd0);
        rst = 1'b1;

        // M0 alone
        pair(1, 32'h800, 0, 0, MW_Word, 0, 0, rd0, rd1);
        chk("m0_fetch_0x800", rd0, 32'h00000013);

        // M1 store/load word, then byte merge
        pair(0, 0, 1, 1, MW_Word, 32'h900, 32'hDEADBEEF, rd0, rd1);
        pair(0, 0, 1, 0, MW_Word, 32'h900, 32'h0, rd0, rd1);
        chk("lw_0x900", rd1, 32'hDEADBEEF);
        pair(0, 0, 1, 1, MW_Byte, 32'h901, 32'h5A, rd0, rd1);
        pair(0, 0, 1, 0, MW_Word, 32'h900, 32'h0, rd0, rd1);
        chk("lw_after_sb", rd1, 32'hDEAD5AEF);

        // Continuous contention: six grants alternating M0, M1, ... three cycles apart
        bus.m0_addr = 32'h800;
        bus.m1_we = 1'b0;  bus.m1_size = MW_Word;  bus.m1_addr = 32'h900;
        bus.m0_req = 1'b1;  bus.m1_req = 1'b1;
        n = 0;
        cyc = 0;
        while (n < 6 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.m0_ack || bus.m1_ack) begin
                chk("cont_overlap", 32'(bus.m0_ack & bus.m1_ack), 32'd0);
                chk("cont_order", 32'(bus.m1_ack), 32'(n[0]));
                chk("cont_spacing", cyc, 2 + 3 * n);
                chk("cont_rdata", bus.m1_ack ? bus.m1_rdata : bus.m0_rdata,
                    bus.m1_ack ? ref_rd(32'h900, MW_Word) : ref_rd(32'h800, MW_Word));
                n++;
                if (n == 6) begin
                    bus.m0_req = 1'b0;
                    bus.m1_req = 1'b0;
                end
            end
        end
        chk("cont_count", n, 6);
        exp_last = M1;
        @(posedge clk); #1;

        // Rejected accesses must not touch memory
        wc = wr_cnt;
        pair(0, 0, 1, 1, MW_Word, 32'h902, 32'h11111111, rd0, rd1);
        pair(0, 0, 1, 1, MW_Half, 32'h903, 32'h2222, rd0, rd1);
        pair(1, 32'h1000, 0, 0, MW_Word, 0, 0, rd0, rd1);
        chk("err_no_write", wr_cnt, wc);
        chk("err_mem_intact", {mem[12'h903], mem[12'h902], mem[12'h901], mem[12'h900]}, 32'hDEAD5AEF);

        // Reset during ISSUE of a write (target outside the randomized window)
        bus.m1_we = 1'b1;  bus.m1_size = MW_Word;  bus.m1_addr = 32'h944;  bus.m1_wdata = 32'hA5A5A5A5;
        bus.m1_req = 1'b1;
        @(posedge clk); #1;
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ack", {30'd0, bus.m0_ack, bus.m1_ack}, 32'd0);
        chk("mid_rst_enwr", 32'(bus.mem_enwr), 32'(MM_ENB_R));
        bus.m1_req = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_noack", {30'd0, bus.m0_ack, bus.m1_ack}, 32'd0);
        rst = 1'b1;
        exp_last = M1;
        pair(1, 32'h800, 0, 0, MW_Word, 0, 0, rd0, rd1);
        chk("post_rst_fetch", rd0, 32'h00000013);

        // Sequential fetch until the sentinel
        a = 32'h800;
        k = 0;
        done = 1'b0;
        while (!done && k < 32) begin
            pair(1, a, 0, 0, MW_Word, 0, 0, rd0, rd1);
            chk("fetch_image", rd0, img[k < IMG_N ? k : IMG_N - 1]);
            if (rd0 == 32'h0000FFFF) done = 1'b1;
            a += 32'd4;
            k++;
        end
        chk("fetch_len", k, IMG_N);

        // Randomized single and contended accesses
        for (int it = 0; it < 60; it++) begin
            sel = $urandom_range(0, 2);
            pair(sel != 1, pick_addr(), sel != 0, 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 2)), pick_addr(), $urandom, rd0, rd1);
        end
        for (int i = 32'h900; i < 32'h940; i++)
            chk("final_mem", {24'd0, mem[i]}, {24'd0, ref_mem[i]});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
